// File: rtl/write_scheduler.sv
// Write-side sequencer for the sample ring buffer: admits ADC samples in HPL-word blocks,
// reserves ring space by word credits and drops whole blocks that do not fit.
// Optional build macro OVERFLOW_COUNT_EN adds the saturating drop_cnt counter and port.
module write_scheduler #(
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  live_rising,
    input  logic                  adc_valid,
    input  logic                  read_done,
    input  logic [9:0]            HALF_PACKAGE_LENGTH,
    input  logic [14:0]           MEMORY_DEPTH,
    output logic                  wen,
    output logic [14:0]           waddr,
    output logic                  read_start,
    output logic [14:0]           used_words,
    output logic                  cfg_err,
    output logic                  overflow,
`ifdef OVERFLOW_COUNT_EN
    output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, ADMIT = 2'd1, FILL = 2'd2, DROP = 2'd3} state_t;

    state_t      state, state_next;
    logic [9:0]  hpl_q;
    logic [14:0] depth_q;
    logic [9:0]  cnt, cnt_next;
    logic        fits, last, reserve, adv, done_block, drop_block, cfg_bad, release_blk;
    logic [15:0] used_sum, rel_amt;
    logic [14:0] used_next, waddr_next;

    assign state_dbg   = state;
    assign fits        = (depth_q - used_words) >= {5'd0, hpl_q};
    assign last        = (cnt == hpl_q - 10'd1);
    assign cfg_bad     = (HALF_PACKAGE_LENGTH == 10'd0) || ({5'd0, HALF_PACKAGE_LENGTH} > MEMORY_DEPTH);
    assign release_blk = read_done && (state != IDLE);
    assign waddr_next  = (waddr == depth_q - 15'd1) ? 15'd0 : waddr + 15'd1;

    // Reservation and release are netted in one step; an early release floors at zero.
    assign used_sum  = {1'b0, used_words} + (reserve ? {6'd0, hpl_q} : 16'd0);
    assign rel_amt   = release_blk ? {6'd0, hpl_q} : 16'd0;
    assign used_next = (used_sum < rel_amt) ? 15'd0 : 15'(used_sum - rel_amt);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        wen        = 1'b0;
        reserve    = 1'b0;
        adv        = 1'b0;
        done_block = 1'b0;
        drop_block = 1'b0;
        case (state)
            IDLE: ;
            ADMIT: begin
                // Admission is decided once, on the first sample of the block.
                if (adc_valid) begin
                    if (fits) begin
                        wen     = 1'b1;
                        reserve = 1'b1;
                        adv     = 1'b1;
                        if (last) done_block = 1'b1;
                        else begin
                            cnt_next   = 10'd1;
                            state_next = FILL;
                        end
                    end else begin
                        if (last) drop_block = 1'b1;
                        else begin
                            cnt_next   = 10'd1;
                            state_next = DROP;
                        end
                    end
                end
            end
            FILL: begin
                if (adc_valid) begin
                    wen = 1'b1;
                    adv = 1'b1;
                    if (last) begin
                        done_block = 1'b1;
                        cnt_next   = 10'd0;
                        state_next = ADMIT;
                    end else cnt_next = cnt + 10'd1;
                end
            end
            DROP: begin
                if (adc_valid) begin
                    if (last) begin
                        drop_block = 1'b1;
                        cnt_next   = 10'd0;
                        state_next = ADMIT;
                    end else cnt_next = cnt + 10'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (live_rising) wen = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hpl_q      <= 10'd0;
            depth_q    <= 15'd0;
            cnt        <= 10'd0;
            waddr      <= 15'd0;
            used_words <= 15'd0;
            read_start <= 1'b0;
            cfg_err    <= 1'b0;
            overflow   <= 1'b0;
        end else if (live_rising) begin
            state      <= cfg_bad ? IDLE : ADMIT;
            hpl_q      <= HALF_PACKAGE_LENGTH;
            depth_q    <= MEMORY_DEPTH;
            cfg_err    <= cfg_bad;
            cnt        <= 10'd0;
            waddr      <= 15'd0;
            used_words <= 15'd0;
            read_start <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            used_words <= used_next;
            read_start <= done_block;
            // Dropped blocks leave waddr frozen so the next block lands where the reader expects.
            if (adv) waddr <= waddr_next;
            if (drop_block) overflow <= 1'b1;
        end
    end

`ifdef OVERFLOW_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= '0;
        else if (live_rising) drop_cnt <= '0;
        else if (drop_block && (drop_cnt != {DROP_CNT_W{1'b1}})) drop_cnt <= drop_cnt + 1'b1;
    end
`endif

endmodule
